// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin frame arbiter sharing one UART transmitter between two byte streams.
// Optional per-byte watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  output logic       s0_grant,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       s1_grant,
  output logic       tx_enable,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       arb_err
);
  typedef enum logic [1:0] {IDLE, SEND, NEXT, GAP} state_t;
  typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] wd_t;
  state_t state, state_n;
  logic ptr, own, last_q, win, sel, acc, own_valid, to;
  logic [15:0] gap_cnt;
  always_comb begin
    own_valid = own ? s1_valid : s0_valid;
    win = ptr ? s1_valid : !s0_valid;
    sel = (state == IDLE) ? win : own;
    acc = (state == IDLE) ? (s0_valid | s1_valid) : (state == NEXT) && own_valid;
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? SEND : IDLE;
      SEND:    state_n = tx_done ? (last_q ? GAP : NEXT) : (to ? GAP : SEND);
      NEXT:    state_n = own_valid ? SEND : (to ? GAP : NEXT);
      GAP:     state_n = (gap_cnt == 16'd0) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      own       <= 1'b0;
      last_q    <= 1'b0;
      gap_cnt   <= '0;
      tx_enable <= 1'b0;
      tx_data   <= '0;
      s0_ready  <= 1'b0;
      s1_ready  <= 1'b0;
      s0_grant  <= 1'b0;
      s1_grant  <= 1'b0;
    end else begin
      state    <= state_n;
      s0_ready <= acc && !sel;
      s1_ready <= acc && sel;
      gap_cnt  <= (state != GAP) ? 16'(GAP_CYCLES - 1) : gap_cnt - 16'd1;
      if (acc) begin
        own       <= sel;
        tx_data   <= sel ? s1_data : s0_data;
        last_q    <= sel ? s1_last : s0_last;
        tx_enable <= 1'b1;
        s0_grant  <= !sel;
        s1_grant  <= sel;
      end else if (state_n == GAP && state != GAP) begin
        // frame finished or aborted: release and hand priority to the other side
        ptr       <= !own;
        tx_enable <= 1'b0;
        s0_grant  <= 1'b0;
        s1_grant  <= 1'b0;
      end else if (state == SEND && tx_done) begin
        tx_enable <= 1'b0;
      end
    end
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  wd_t wd;
  assign to = (state == SEND || state == NEXT) && wd == wd_t'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      arb_err <= 1'b0;
    end else begin
      wd      <= acc ? wd_t'(1) : (state == SEND || state == NEXT) ? wd + wd_t'(1) : '0;
      arb_err <= to && !(state == SEND ? tx_done : own_valid);
    end
  end
`else
  assign to      = 1'b0;
  assign arb_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (GAP_CYCLES=4).
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0, tx_done = 1'b0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic s0_ready, s0_grant, s1_ready, s1_grant, tx_enable, arb_err;
  logic [7:0] tx_data;
  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready), .s0_grant(s0_grant),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready), .s1_grant(s1_grant),
    .tx_enable(tx_enable), .tx_data(tx_data), .tx_done(tx_done), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit l);
    if (r) begin
      s1_valid = v; s1_data = d; s1_last = l;
    end else begin
      s0_valid = v; s0_data = d; s0_last = l;
    end
  endtask

  task automatic wait_ready(input bit r, input int max, output bit got, output int n);
    got = 1'b0;
    n = 0;
    for (int i = 0; i < max; i++) begin
      step();
      if (r ? s1_ready : s0_ready) begin
        got = 1'b1;
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic done_pulse(input int dly);
    repeat (dly) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if ({tx_enable, tx_data, s0_ready, s1_ready, s0_grant, s1_grant, arb_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_values got %b expected all zero", {tx_enable, tx_data, s0_ready, s1_ready, s0_grant, s1_grant, arb_err});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({tx_enable, s0_ready, s1_ready, s0_grant, s1_grant} !== 5'd0) begin
      errors++;
      $display("FAIL reset_release got %b expected 00000", {tx_enable, s0_ready, s1_ready, s0_grant, s1_grant});
    end
  endtask

  task automatic test_single_frame();
    bit got;
    int n;
    drive(0, 1, 8'h41, 0);
    wait_ready(0, 5, got, n);
    checks++;
    if (!got || n != 1) begin errors++; $display("FAIL sf_latency got %0d/%0d expected 1/1", got, n); end
    checks++;
    if ({s0_grant, s1_grant, tx_enable, tx_data} !== {3'b101, 8'h41}) begin
      errors++; $display("FAIL sf_byte0 got %b_%h expected 101_41", {s0_grant, s1_grant, tx_enable}, tx_data);
    end
    drive(0, 1, 8'h54, 0);
    step();
    checks++;
    if ({s0_ready, tx_enable, tx_data} !== {2'b01, 8'h41}) begin
      errors++; $display("FAIL sf_pulse got %b_%h expected 01_41", {s0_ready, tx_enable}, tx_data);
    end
    done_pulse(19);
    checks++;
    if ({tx_enable, s0_grant} !== 2'b01) begin errors++; $display("FAIL sf_done0 got %b expected 01", {tx_enable, s0_grant}); end
    step();
    checks++;
    if ({s0_ready, tx_enable, tx_data} !== {2'b11, 8'h54}) begin
      errors++; $display("FAIL sf_byte1 got %b_%h expected 11_54", {s0_ready, tx_enable}, tx_data);
    end
    drive(0, 1, 8'h0D, 1);
    step();
    done_pulse(19);
    step();
    checks++;
    if ({s0_ready, tx_enable, tx_data} !== {2'b11, 8'h0D}) begin
      errors++; $display("FAIL sf_byte2 got %b_%h expected 11_0d", {s0_ready, tx_enable}, tx_data);
    end
    drive(0, 0, 8'h00, 0);
    step();
    done_pulse(19);
    checks++;
    if ({s0_grant, s1_grant, tx_enable, arb_err} !== 4'b0000) begin
      errors++; $display("FAIL sf_end got %b expected 0000", {s0_grant, s1_grant, tx_enable, arb_err});
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++;
    if ({s0_ready, s1_ready, tx_enable, s0_grant, s1_grant} !== 5'd0) begin
      errors++; $display("FAIL sf_spur_gap got %b expected 00000", {s0_ready, s1_ready, tx_enable, s0_grant, s1_grant});
    end
    repeat (4) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    checks++;
    if ({s0_ready, s1_ready, tx_enable, s0_grant, s1_grant} !== 5'd0) begin
      errors++; $display("FAIL sf_spur_idle got %b expected 00000", {s0_ready, s1_ready, tx_enable, s0_grant, s1_grant});
    end
  endtask

  task automatic test_tie();
    bit got;
    bit bad;
    int n;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    drive(0, 1, 8'hA0, 0);
    drive(1, 1, 8'hB0, 0);
    step();
    checks++;
    if ({s0_ready, s1_ready, s0_grant, s1_grant, tx_data} !== {4'b1010, 8'hA0}) begin
      errors++; $display("FAIL tie_first got %b_%h expected 1010_a0", {s0_ready, s1_ready, s0_grant, s1_grant}, tx_data);
    end
    drive(0, 1, 8'hA1, 1);
    step();
    done_pulse(3);
    step();
    checks++;
    if ({s0_ready, tx_data} !== {1'b1, 8'hA1}) begin errors++; $display("FAIL tie_a1 got %b_%h expected 1_a1", s0_ready, tx_data); end
    drive(0, 0, 8'h00, 0);
    step();
    done_pulse(3);
    bad = 1'b0;
    repeat (4) begin
      if (s1_ready || s1_grant || s0_grant) bad = 1'b1;
      step();
    end
    checks++;
    if (bad) begin errors++; $display("FAIL tie_gap got early grant expected none for 4 gap cycles"); end
    step();
    checks++;
    if ({s1_ready, s1_grant, s0_grant, tx_data} !== {3'b110, 8'hB0}) begin
      errors++; $display("FAIL tie_second got %b_%h expected 110_b0", {s1_ready, s1_grant, s0_grant}, tx_data);
    end
    drive(1, 1, 8'hB1, 1);
    step();
    done_pulse(3);
    step();
    checks++;
    if ({s1_ready, tx_data} !== {1'b1, 8'hB1}) begin errors++; $display("FAIL tie_b1 got %b_%h expected 1_b1", s1_ready, tx_data); end
    drive(1, 0, 8'h00, 0);
    step();
    done_pulse(3);
    drive(0, 1, 8'hC0, 1);
    drive(1, 1, 8'hD0, 1);
    wait_ready(0, 10, got, n);
    checks++;
    if (!got || n != 5 || s1_ready !== 1'b0) begin
      errors++; $display("FAIL tie_again got %0d/%0d/%b expected 1/5/0", got, n, s1_ready);
    end
    drive(0, 0, 8'h00, 0);
    step();
    done_pulse(3);
    checks++;
    if (s0_grant !== 1'b0) begin errors++; $display("FAIL tie_onebyte got %b expected 0", s0_grant); end
    wait_ready(1, 10, got, n);
    checks++;
    if (!got || n != 5 || tx_data !== 8'hD0) begin
      errors++; $display("FAIL tie_again_s1 got %0d/%0d/%h expected 1/5/d0", got, n, tx_data);
    end
    drive(1, 0, 8'h00, 0);
    step();
    done_pulse(3);
    repeat (6) step();
  endtask

  task automatic test_lockout();
    bit got;
    bit bad;
    int n;
    drive(0, 1, 8'hE0, 0);
    step();
    checks++;
    if ({s0_ready, s0_grant} !== 2'b11) begin errors++; $display("FAIL lock_start got %b expected 11", {s0_ready, s0_grant}); end
    drive(0, 0, 8'h00, 0);
    step();
    done_pulse(3);
    drive(1, 1, 8'hF0, 1);
    bad = 1'b0;
    repeat (10) begin
      step();
      if (s1_ready || s1_grant || !s0_grant) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL lock_stall got s1 access expected none during s0 stall"); end
    drive(0, 1, 8'hE1, 1);
    step();
    checks++;
    if ({s0_ready, s1_ready, tx_data} !== {2'b10, 8'hE1}) begin
      errors++; $display("FAIL lock_e1 got %b_%h expected 10_e1", {s0_ready, s1_ready}, tx_data);
    end
    drive(0, 0, 8'h00, 0);
    step();
    done_pulse(3);
    checks++;
    if ({s0_grant, s1_grant} !== 2'b00) begin errors++; $display("FAIL lock_release got %b expected 00", {s0_grant, s1_grant}); end
    wait_ready(1, 10, got, n);
    checks++;
    if (!got || n != 5 || s1_grant !== 1'b1 || tx_data !== 8'hF0) begin
      errors++; $display("FAIL lock_s1 got %0d/%0d/%b/%h expected 1/5/1/f0", got, n, s1_grant, tx_data);
    end
    drive(1, 0, 8'h00, 0);
    step();
    done_pulse(3);
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 8'h55, 0);
    step();
    drive(0, 0, 8'h00, 0);
    checks++;
    if ({tx_enable, s0_grant} !== 2'b11) begin errors++; $display("FAIL rm_inflight got %b expected 11", {tx_enable, s0_grant}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_enable, tx_data, s0_ready, s1_ready, s0_grant, s1_grant, arb_err} !== 14'd0) begin
      errors++; $display("FAIL rm_async got %b expected all zero", {tx_enable, tx_data, s0_ready, s1_ready, s0_grant, s1_grant, arb_err});
    end
    step();
    rst_n = 1'b1;
    drive(1, 1, 8'h31, 1);
    step();
    checks++;
    if ({s1_ready, s1_grant, s0_grant, tx_enable, tx_data} !== {4'b1101, 8'h31}) begin
      errors++; $display("FAIL rm_fresh got %b_%h expected 1101_31", {s1_ready, s1_grant, s0_grant, tx_enable}, tx_data);
    end
    drive(1, 0, 8'h00, 0);
    step();
    done_pulse(3);
    checks++;
    if ({s1_grant, tx_enable} !== 2'b00) begin errors++; $display("FAIL rm_end got %b expected 00", {s1_grant, tx_enable}); end
    repeat (6) step();
  endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
  task automatic test_timeout();
    drive(0, 1, 8'h77, 0);
    step();
    drive(0, 0, 8'h00, 0);
    checks++;
    if ({s0_ready, tx_enable} !== 2'b11) begin errors++; $display("FAIL to_accept got %b expected 11", {s0_ready, tx_enable}); end
    repeat (98) step();
    checks++;
    if ({arb_err, tx_enable} !== 2'b01) begin errors++; $display("FAIL to_early got %b expected 01", {arb_err, tx_enable}); end
    step();
    checks++;
    if ({arb_err, tx_enable, s0_grant} !== 3'b100) begin
      errors++; $display("FAIL to_abort got %b expected 100", {arb_err, tx_enable, s0_grant});
    end
    step();
    checks++;
    if (arb_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %b expected 0", arb_err); end
    repeat (6) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_tie();
    test_lockout();
    test_reset_mid();
`ifdef UART_TX_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level arbiter that shares the single GSM-module UART transmitter (`uart_sentdata_mess` with its `uart_bps_mess` baud generator) between two command sources: the emergency-calling sequencer (requester 0) and the SMS/message sequencer (requester 1). Each source streams AT-command bytes with a valid/ready handshake. The arbiter locks the transmitter to one source for a whole frame, ended by a byte flagged `last`, and alternates priority round-robin between frames. It drives `tx_enable`/`tx_data` into the transmitter and consumes its `tx_done`.

## Interface
Parameters:
- `GAP_CYCLES`, default 16: idle clock cycles forced between frames; valid range 1..65535.
- `TIMEOUT_CYCLES`, default 50_000_000: watchdog limit per byte. Used only with `UART_TX_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `s0_valid`  in  1  requester 0 has a byte.
- `s0_data`  in  8  requester 0 byte.
- `s0_last`  in  1  requester 0 byte is the final byte of its frame.
- `s0_ready`  out  1  one-cycle pulse: requester 0 byte accepted.
- `s0_grant`  out  1  requester 0 owns the transmitter.
- `s1_valid`, `s1_data`, `s1_last`, `s1_ready`, `s1_grant`: same as the `s0_*` ports, for requester 1.
- `tx_enable`  out  1  level; high while a byte is in flight; also starts the baud generator.
- `tx_data`  out  8  byte to transmit; stable while `tx_enable` is high.
- `tx_done`  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- `arb_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, SEND, NEXT, GAP. Priority pointer `ptr` is 1 bit; reset value 0 (requester 0 preferred).
- **IDLE**
  - If any `sX_valid` is high, select the winner: the requester at `ptr` if it is valid, otherwise the other.
  - On the clock edge: latch `tx_data`, set `sX_grant`, pulse `sX_ready`, set `tx_enable`, and latch `last`. Go to SEND.
- **SEND**
  - Hold `tx_enable` and `tx_data`.
  - On `tx_done`, drop `tx_enable`.
  - If the latched `last` is 1, go to GAP; otherwise go to NEXT.
- **NEXT**
  - Grant is kept; wait for the granted `sX_valid`.
  - On valid: latch the byte, pulse `sX_ready`, raise `tx_enable`, and go to SEND.
  - The other requester is ignored.
- **GAP**
  - Grant is dropped on entry, and `ptr` is set to the other requester.
  - Count `GAP_CYCLES`, then go to IDLE.
- Ignored inputs:
  - `tx_done` is ignored outside SEND.
  - A non-granted requester's valid is ignored until IDLE; its data must be held.
- A requester may deassert valid in NEXT indefinitely. The frame stays locked (see Configuration).
- A byte with `last`=1 accepted in IDLE is a one-byte frame.
- Reset mid-frame: all state clears immediately and `tx_enable` drops. The transmitter shares `rst_n`. The requester sees no further `ready` and must restart its frame.

## Timing
- Reset values: `tx_enable`=0, `tx_data`=8'h00, `s0_ready`=`s1_ready`=0, `s0_grant`=`s1_grant`=0, `arb_err`=0, state IDLE, `ptr`=0.
- Accept latency: valid sampled high in cycle t (IDLE or NEXT) gives `ready`, `grant` (if newly set) and `tx_enable` all high in cycle t+1. `ready` is high for exactly cycle t+1, and the requester advances its data on that edge.
- `tx_done` in cycle t: `tx_enable` is low in t+1.
  - If not last, the next byte is accepted no earlier than the edge ending t+1.
  - If last, grant is low in t+1, GAP spans t+1..t+`GAP_CYCLES`, and IDLE is reached in t+`GAP_CYCLES`+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A per-byte counter runs in SEND and NEXT and restarts on each accept.
  - When it reaches `TIMEOUT_CYCLES`: drop `tx_enable`, pulse `arb_err` for one cycle, drop grant, advance `ptr`, and go to GAP.
  - The aborted requester sees no further `ready` for that frame.
- Not defined: no counter is built and `arb_err` is tied 0. A stalled transmitter or requester holds the grant until reset.

## Test plan
- Single frame: requester 0 sends 8'h41, 8'h54, 8'h0D (last); model `tx_done` 20 cycles after each `tx_enable` rise. Required: three `ready` pulses, `tx_data` sequence 41/54/0D, `s0_grant` low the cycle after the third `tx_done`.
- Tie after reset: both valid in the same cycle, each sending a 2-byte frame. Required: requester 0 served first, requester 1 granted only after `GAP_CYCLES`; the next tie goes to requester 0 again (`ptr` alternates).
- Lockout: `s1_valid` rises during requester 0's NEXT stall. Required: no `s1_ready` and no `s1_grant` until requester 0's last byte completes plus the gap.
- Spurious `tx_done` pulsed in IDLE and GAP. Required: no state change and no `ready`.
- Reset asserted mid-byte (`tx_enable`=1). Required: all outputs at reset values asynchronously; after release, a fresh frame from requester 1 is accepted normally.
- With `UART_TX_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, `tx_done` never returned. Required: `arb_err` pulses in the 100th cycle after accept, then `tx_enable`=0 and grant is released.
